// File: rtl/residual_frame_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// residual_frame_sequencer_pkg
//   Shared encoder constants for the residual frame sequencer: FSM state
//   encoding, default frame geometry and a small helper to validate the
//   requested predictor order.
// ----------------------------------------------------------------------------
package residual_frame_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_STREAM = 2'd2,
        ST_GAP    = 2'd3
    } state_e;

    localparam int DEF_BLOCK_SIZE = 4096;
    localparam int DEF_MAX_ORDER  = 12;
    localparam int DEF_GAP_CYCLES = 4;

    // Sample counter width: must hold BLOCK_SIZE itself (order 0 -> 4096 pops).
    localparam int CNT_W  = 13;
    localparam int DATA_W = 16;
    localparam int ORD_W  = 4;

    function automatic logic order_legal(input logic [ORD_W-1:0] order,
                                         input int max_order);
        return int'(order) <= max_order;
    endfunction

endpackage

// File: rtl/residual_frame_sequencer.sv
// ----------------------------------------------------------------------------
// residual_frame_sequencer
//   Moves one frame of residuals from a show-ahead FIFO to the compressor.
//   A frame request in IDLE latches the predictor order, pulses the
//   compressor's frame-done input, then pops exactly BLOCK_SIZE - order words
//   (stalling on an empty FIFO), registers each into oResidual/oValid, and
//   finally idles GAP_CYCLES cycles so the compressor can flush.
//
// Ports
//   iClock, iReset      : rising-edge clock, synchronous active-high reset
//   iEnable             : global advance; low freezes every register
//   iStart, iOrder      : frame request and its predictor order (IDLE only)
//   iFifoEmpty, iFifoData, oFifoRead : show-ahead FIFO head and pop strobe
//   oFrameDone, oM      : frame-start pulse and latched order to compressor
//   oValid, oResidual   : residual stream to compressor (1-cycle latency)
//   oReady              : high while IDLE
//   oFrameComplete      : pulse once the flush gap has elapsed
//   oError              : pulse after a request with an illegal order
// ----------------------------------------------------------------------------
module residual_frame_sequencer
    import residual_frame_sequencer_pkg::*;
#(
    parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int MAX_ORDER  = DEF_MAX_ORDER,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                     iClock,
    input  logic                     iReset,
    input  logic                     iEnable,
    input  logic                     iStart,
    input  logic [ORD_W-1:0]         iOrder,
    input  logic                     iFifoEmpty,
    input  logic signed [DATA_W-1:0] iFifoData,
    output logic                     oFifoRead,
    output logic                     oFrameDone,
    output logic [ORD_W-1:0]         oM,
    output logic                     oValid,
    output logic signed [DATA_W-1:0] oResidual,
    output logic                     oReady,
    output logic                     oFrameComplete,
    output logic                     oError
);

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [ORD_W-1:0]           m_q, m_d;
    logic                       valid_q, valid_d;
    logic signed [DATA_W-1:0]   residual_q, residual_d;
    logic                       frame_done_q, frame_done_d;
    logic                       complete_q, complete_d;
    logic                       error_q, error_d;
    logic                       pop;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        m_d          = m_q;
        valid_d      = valid_q;
        residual_d   = residual_q;
        frame_done_d = frame_done_q;
        complete_d   = complete_q;
        error_d      = error_q;
        pop          = 1'b0;

        // With iEnable low everything above simply holds, so a pending pulse
        // or residual is presented again on the next enabled cycle.
        if (iEnable) begin
            valid_d      = 1'b0;
            frame_done_d = 1'b0;
            complete_d   = 1'b0;
            error_d      = 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (iStart) begin
                        if (order_legal(iOrder, MAX_ORDER)) begin
                            m_d          = iOrder;
                            cnt_d        = CNT_W'(BLOCK_SIZE) - CNT_W'(iOrder);
                            frame_done_d = 1'b1;
                            state_d      = ST_START;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end

                ST_START: begin
                    state_d = ST_STREAM;
                end

                ST_STREAM: begin
                    if (!iFifoEmpty) begin
                        pop        = 1'b1;
                        valid_d    = 1'b1;
                        residual_d = iFifoData;
                        // The last pop reloads the same counter for the gap.
                        if (cnt_q == CNT_W'(1)) begin
                            cnt_d   = CNT_W'(GAP_CYCLES);
                            state_d = ST_GAP;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end

                ST_GAP: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d      = '0;
                        complete_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            m_q          <= '0;
            valid_q      <= 1'b0;
            residual_q   <= '0;
            frame_done_q <= 1'b0;
            complete_q   <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            m_q          <= m_d;
            valid_q      <= valid_d;
            residual_q   <= residual_d;
            frame_done_q <= frame_done_d;
            complete_q   <= complete_d;
            error_q      <= error_d;
        end
    end

    // Reset masks the pop so an abandoned frame never consumes a FIFO word
    // in the reset cycle itself.
    assign oFifoRead      = pop && !iReset;
    assign oValid         = valid_q && iEnable;
    assign oResidual      = residual_q;
    assign oFrameDone     = frame_done_q;
    assign oFrameComplete = complete_q;
    assign oError         = error_q;
    assign oM             = m_q;
    assign oReady         = (state_q == ST_IDLE);

endmodule

// File: tb/tb_residual_frame_sequencer.sv
module tb_residual_frame_sequencer;

    localparam int BS    = 4096;
    localparam int MO    = 12;
    localparam int GC    = 4;
    localparam int SRC_N = 32768;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               iReset  = 1'b1;
    logic               iEnable = 1'b0;
    logic               iStart  = 1'b0;
    logic [3:0]         iOrder  = 4'd0;
    logic               iFifoEmpty;
    logic signed [15:0] iFifoData;
    logic               oFifoRead, oFrameDone, oValid, oReady, oFrameComplete, oError;
    logic [3:0]         oM;
    logic signed [15:0] oResidual;

    residual_frame_sequencer dut (
        .iClock(clk), .iReset(iReset), .iEnable(iEnable), .iStart(iStart),
        .iOrder(iOrder), .iFifoEmpty(iFifoEmpty), .iFifoData(iFifoData),
        .oFifoRead(oFifoRead), .oFrameDone(oFrameDone), .oM(oM),
        .oValid(oValid), .oResidual(oResidual), .oReady(oReady),
        .oFrameComplete(oFrameComplete), .oError(oError)
    );

    // Bench-side show-ahead FIFO: a fixed random word stream.
    logic signed [15:0] src [SRC_N];
    int   rd_ptr = 0;
    logic force_empty = 1'b0, rand_stall_en = 1'b0, stall_bit = 1'b0;

    assign iFifoEmpty = force_empty || stall_bit || (rd_ptr >= SRC_N);
    assign iFifoData  = (rd_ptr < SRC_N) ? src[rd_ptr] : 16'sd0;

    always @(posedge clk) if (oFifoRead) rd_ptr <= rd_ptr + 1;
    always @(negedge clk) stall_bit <= rand_stall_en && ($urandom_range(0, 3) == 0);

    // Reference model state: expected frames and residual words.
    typedef struct { int order; int extra; } frame_t;
    frame_t exp_frames[$];
    int     exp_res[$];
    int     model_ptr = 0;
    int     exp_done = 0, exp_comp = 0, exp_err = 0;
    int     n_done = 0, n_comp = 0, n_err = 0;
    int     n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int     cyc = 0, frame_rcv = 0, first_v = -1, last_v = 0;
    frame_t cur;
    logic   cur_valid = 1'b0;
    logic   prev_fd = 1'b0, prev_fc = 1'b0, prev_er = 1'b0;

    initial begin
        cur.order = 0; cur.extra = -1;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (iReset) chk("pop_in_reset", int'(oFifoRead), 0);
            if (!iEnable) begin
                chk("disabled_valid", int'(oValid), 0);
                chk("disabled_pop", int'(oFifoRead), 0);
            end
            if (oFrameDone && iEnable) begin
                chk("frame_done_width", int'(prev_fd), 0);
                n_done++;
                if (exp_frames.size() == 0) begin
                    chk("unexpected_frame_done", 1, 0);
                end else begin
                    cur = exp_frames.pop_front();
                    cur_valid = 1'b1;
                    chk("oM_at_frame_done", int'(oM), cur.order);
                end
                frame_rcv = 0; first_v = -1;
            end
            if (oValid) begin
                if (exp_res.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    chk("residual", int'(oResidual), exp_res.pop_front());
                end
                frame_rcv++;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end
            if (oFrameComplete && iEnable) begin
                chk("complete_width", int'(prev_fc), 0);
                n_comp++;
                chk("complete_has_frame", int'(cur_valid), 1);
                chk("frame_pop_count", frame_rcv, BS - cur.order);
                chk("gap_after_last_valid", cyc - last_v, GC);
                if (cur.extra >= 0)
                    chk("frame_valid_span", last_v - first_v + 1, BS - cur.order + cur.extra);
                cur_valid = 1'b0;
            end
            if (oError && iEnable) begin
                chk("error_width", int'(prev_er), 0);
                n_err++;
            end
            prev_fd = oFrameDone && iEnable;
            prev_fc = oFrameComplete && iEnable;
            prev_er = oError && iEnable;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!oReady && n < 20000);
        chk({name, "_timeout"}, int'(n >= 20000), 0);
    endtask

    task automatic wait_rcv(input int target, input string name);
        int n = 0;
        while (frame_rcv < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, int'(n >= 20000), 0);
    endtask

    task automatic start_frame(input int order, input int extra);
        frame_t f;
        iStart = 1'b1;
        iOrder = 4'(order);
        if (order <= MO) begin
            f.order = order; f.extra = extra;
            exp_frames.push_back(f);
            exp_done++; exp_comp++;
            for (int i = 0; i < BS - order; i++) exp_res.push_back(int'(src[model_ptr + i]));
            model_ptr += BS - order;
        end else begin
            exp_err++;
        end
        @(negedge clk);
        iStart = 1'b0;
    endtask

    task automatic check_cleared(input string name);
        chk({name, "_ready"}, int'(oReady), 1);
        chk({name, "_valid"}, int'(oValid), 0);
        chk({name, "_pop"}, int'(oFifoRead), 0);
        chk({name, "_frame_done"}, int'(oFrameDone), 0);
        chk({name, "_complete"}, int'(oFrameComplete), 0);
        chk({name, "_error"}, int'(oError), 0);
        chk({name, "_m"}, int'(oM), 0);
        chk({name, "_residual"}, int'(oResidual), 0);
    endtask

    initial begin
        int ptr0, res0, m0, rcv0, e_ptr0;
        for (int i = 0; i < SRC_N; i++) src[i] = 16'($urandom);

        repeat (3) @(negedge clk);
        iReset = 1'b0; iEnable = 1'b1;
        @(negedge clk);
        check_cleared("reset");

        // Order 7 then order 4, back to back, FIFO never empty.
        start_frame(7, 0);
        wait_ready("frame_a");
        start_frame(4, 0);
        wait_ready("frame_b");

        // Illegal orders.
        start_frame(13, 0);
        chk("ready_after_err13", int'(oReady), 1);
        @(negedge clk);
        start_frame(15, 0);
        chk("ready_after_err15", int'(oReady), 1);
        repeat (2) @(negedge clk);

        // Order 5 with a 10-cycle empty FIFO and an ignored mid-frame request.
        start_frame(5, 10);
        wait_rcv(1000, "frame_c_1000");
        ptr0 = rd_ptr;
        force_empty = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_pop_while_empty", rd_ptr, ptr0);
        force_empty = 1'b0;
        wait_rcv(2000, "frame_c_2000");
        iStart = 1'b1; iOrder = 4'd3;
        @(negedge clk);
        iStart = 1'b0;
        wait_ready("frame_c");
        repeat (10) @(negedge clk);
        chk("ready_after_ignored_start", int'(oReady), 1);

        // Order 0 with random FIFO stalls.
        rand_stall_en = 1'b1;
        start_frame(0, -1);
        wait_ready("frame_d");
        rand_stall_en = 1'b0;
        @(negedge clk);

        // Order 12: freeze for 5 cycles, then reset at residual 2000.
        e_ptr0 = rd_ptr;
        start_frame(12, -1);
        wait_rcv(500, "frame_e_500");
        iEnable = 1'b0;
        ptr0 = rd_ptr; res0 = int'(oResidual); m0 = int'(oM); rcv0 = frame_rcv;
        repeat (5) @(negedge clk);
        chk("freeze_ptr", rd_ptr, ptr0);
        chk("freeze_residual", int'(oResidual), res0);
        chk("freeze_m", int'(oM), m0);
        chk("freeze_rcv", frame_rcv, rcv0);
        iEnable = 1'b1;
        wait_rcv(2000, "frame_e_2000");
        iReset = 1'b1;
        exp_res.delete();
        exp_comp--;
        @(negedge clk);
        iReset = 1'b0;
        chk("reset_pop_total", rd_ptr - e_ptr0, 2000);
        @(negedge clk);
        check_cleared("midframe_reset");
        repeat (20) @(negedge clk);

        chk("residuals_left", exp_res.size(), 0);
        chk("frames_left", exp_frames.size(), 0);
        chk("frame_done_count", n_done, exp_done);
        chk("complete_count", n_comp, exp_comp);
        chk("error_count", n_err, exp_err);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/residual_frame_sequencer.md
RESIDUAL_FRAME_SEQUENCER -- requirements
Module: residual_frame_sequencer

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 4096, samples per frame.
REQ-002 SHALL have parameter MAX_ORDER, default 12, highest legal predictor order.
REQ-003 SHALL have parameter GAP_CYCLES, default 4, idle cycles between frames for compressor flush.
REQ-004 SHALL have port iClock, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port iReset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port iEnable, input, 1, global advance; low freezes all state.
REQ-007 SHALL have port iStart, input, 1, frame request, sampled in IDLE only.
REQ-008 SHALL have port iOrder, input, 4, predictor order for the requested frame.
REQ-009 SHALL have port iFifoEmpty, input, 1, residual FIFO empty flag (show-ahead FIFO).
REQ-010 SHALL have port iFifoData, input, 16 signed, FIFO head word, valid when iFifoEmpty=0.
REQ-011 SHALL have port oFifoRead, output, 1, pop strobe to the residual FIFO.
REQ-012 SHALL have port oFrameDone, output, 1, one-cycle frame-start pulse to the compressor's frame-done input.
REQ-013 SHALL have port oM, output, 4, latched order presented to the compressor's order input.
REQ-014 SHALL have port oValid, output, 1, residual-valid to the compressor.
REQ-015 SHALL have port oResidual, output, 16 signed, residual to the compressor.
REQ-016 SHALL have port oReady, output, 1, high only in IDLE.
REQ-017 SHALL have port oFrameComplete, output, 1, one-cycle pulse at end of GAP.
REQ-018 SHALL have port oError, output, 1, one-cycle pulse on an illegal-order request.

Function
REQ-019 SHALL implement states IDLE, START, STREAM, GAP.
REQ-020 IDLE with iStart=1 and iOrder<=MAX_ORDER SHALL latch oM=iOrder, load the counter with BLOCK_SIZE-iOrder, and go to START.
REQ-021 IDLE with iStart=1 and iOrder>MAX_ORDER SHALL pulse oError the next cycle and remain in IDLE; oM SHALL be unchanged.
REQ-022 START SHALL last exactly one cycle with oFrameDone=1, then go to STREAM.
REQ-023 STREAM: when iFifoEmpty=0, oFifoRead SHALL be 1 combinationally, and the counter SHALL decrement in the same cycle.
REQ-024 Each pop SHALL register oResidual<=iFifoData and oValid<=1, giving a 1-cycle latency; a cycle with no pop SHALL register oValid<=0 and hold oResidual.
REQ-025 An empty FIFO in STREAM SHALL stall without error; the counter SHALL be held and no pop SHALL occur.
REQ-026 The pop that takes the counter to 0 SHALL move the FSM to GAP; exactly BLOCK_SIZE-oM pops SHALL occur per frame.
REQ-027 GAP SHALL count GAP_CYCLES cycles with oFifoRead=0, then pulse oFrameComplete and return to IDLE.
REQ-028 iStart outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-029 iEnable=0 SHALL force oFifoRead=0 and oValid=0, and SHALL freeze the state, counters, oM and oResidual; pulses SHALL be deferred, not lost.
REQ-030 The counter SHALL be 13 bits unsigned; order 0 SHALL give 4096 pops.
REQ-031 oFrameDone, oFrameComplete and oError SHALL never be high for more than one enabled cycle.

Reset
REQ-032 iReset=1 SHALL set state IDLE, all counters 0, and oFifoRead, oFrameDone, oValid, oFrameComplete, oError, oM and oResidual to 0, with oReady=1 on the following cycle.
REQ-033 Reset SHALL override iEnable=0.
REQ-034 Reset mid-frame SHALL abandon the frame without popping the FIFO in the reset cycle and without pulsing oFrameComplete.

Structure
REQ-035 The state encoding and the BLOCK_SIZE, MAX_ORDER and GAP_CYCLES defaults SHALL reside in the shared encoder constants package.
REQ-036 The design SHALL be a single module with no sub-modules; the GAP counter MAY reuse the sample counter.

Verification
REQ-037 Scenario: reset, then iStart with order 7 and the FIFO always non-empty -> oFrameDone for 1 cycle, 4089 pops, oValid high 4089 consecutive cycles, oFrameComplete 4 cycles after the last oValid.
REQ-038 Scenario: back-to-back frames with orders 7 then 4 -> 4089 then 4092 residuals, oM=4 at the second oFrameDone, residual order preserved.
REQ-039 Scenario: FIFO empty for 10 cycles mid-frame -> oValid low 10 cycles, no pop, total pop count unchanged.
REQ-040 Scenario: iStart with order 13 -> oError pulse, oReady stays 1, no oFrameDone.
REQ-041 Scenario: iEnable low 5 cycles in STREAM, then iReset asserted at residual 2000 -> outputs frozen then cleared, FSM in IDLE, no oFrameComplete.
REQ-042 Scenario: iStart asserted during STREAM -> ignored, one frame only.
